// File: rtl/traffic_lights_multi.sv
// N-approach intersection controller: one approach at a time cycles through
// red+yellow / green / blinking green / yellow / all-red, or all heads blink yellow.
module traffic_lights_multi #(
  parameter  int N_DIR        = 4,
  parameter  int TICKS_PER_MS = 2,
  parameter  int BLINK_Y_MS   = 5,
  parameter  int G_BLINK_T    = 4,
  parameter  int STATE_RY_MS  = 3,
  parameter  int DEF_G_MS     = 10,
  parameter  int DEF_Y_MS     = 4,
  parameter  int DEF_CLR_MS   = 2,
  localparam int DIR_W        = $clog2(N_DIR)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [2:0]       cmd_type_i,
  input  logic             cmd_valid_i,
  input  logic [DIR_W-1:0] cmd_dir_i,
  input  logic [15:0]      cmd_data_i,
  input  logic [N_DIR-1:0] req_i,
  output logic [N_DIR-1:0] red_o,
  output logic [N_DIR-1:0] yellow_o,
  output logic [N_DIR-1:0] green_o
);

  localparam int CNT_W  = 16 + $clog2(TICKS_PER_MS) + 1;
  localparam int HALF   = BLINK_Y_MS * TICKS_PER_MS / 2;
  localparam int HALF_W = $clog2(HALF + 1);

  typedef enum logic [2:0] {
    S_OFF, S_UNREG, S_RY, S_GREEN, S_GBLINK, S_YELLOW, S_ALLRED
  } state_t;

  typedef enum logic [2:0] {
    CMD_ON, CMD_OFF, CMD_UNREG, CMD_SET_GREEN,
    CMD_SET_YELLOW, CMD_SET_CLEAR, CMD_SKIP_EN, CMD_RSVD
  } cmd_t;

  state_t             st, st_n;
  cmd_t               cmd;
  logic [DIR_W-1:0]   dir, dir_n, nxt_dir, cand;
  logic [CNT_W-1:0]   cnt, cnt_n, dur;
  logic [HALF_W-1:0]  hcnt, hcnt_n;
  logic               blk, blk_n;
  logic               running, expire, found;
  logic [N_DIR-1:0]   dem, dem_n;
  logic [N_DIR-1:0]   red_n, yellow_n, green_n;
  logic [15:0]        g_time [N_DIR];
  logic [15:0]        y_time, clr_time;
  logic               skip_en;

  always_comb cmd = cmd_t'(cmd_type_i);

  always_comb begin
    dur = '1;
    case (st)
      S_RY:     dur = CNT_W'(STATE_RY_MS * TICKS_PER_MS);
      S_GREEN:  dur = CNT_W'(g_time[dir]) * CNT_W'(TICKS_PER_MS);
      S_GBLINK: dur = CNT_W'(2 * HALF * G_BLINK_T);
      S_YELLOW: dur = CNT_W'(y_time) * CNT_W'(TICKS_PER_MS);
      S_ALLRED: dur = CNT_W'(clr_time) * CNT_W'(TICKS_PER_MS);
      default:  dur = '1;
    endcase
  end

  assign running = (st != S_OFF) && (st != S_UNREG);
  assign expire  = running && (cnt == dur - CNT_W'(1));

  // Round-robin search starting after the active approach; the active one is tried last.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    nxt_dir = DIR_W'((32'(dir) + 32'd1) % unsigned'(N_DIR));
    for (int unsigned i = 1; i <= unsigned'(N_DIR); i++) begin
      cand = DIR_W'((32'(dir) + i) % unsigned'(N_DIR));
      if (skip_en && !found && dem[cand]) begin
        nxt_dir = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    st_n   = st;
    dir_n  = dir;
    cnt_n  = cnt + CNT_W'(1);
    hcnt_n = hcnt;
    blk_n  = blk;
    if (st == S_UNREG || st == S_GBLINK) begin
      if (hcnt == HALF_W'(HALF - 1)) begin
        hcnt_n = '0;
        blk_n  = ~blk;
      end else begin
        hcnt_n = hcnt + HALF_W'(1);
      end
    end
    if (expire) begin
      cnt_n = '0;
      case (st)
        S_RY:     st_n = S_GREEN;
        S_GREEN: begin
          st_n   = S_GBLINK;
          hcnt_n = '0;
          blk_n  = 1'b0;
        end
        S_GBLINK: st_n = S_YELLOW;
        S_YELLOW: st_n = S_ALLRED;
        S_ALLRED: begin
          st_n  = S_RY;
          dir_n = nxt_dir;
        end
        default: ;
      endcase
    end
    // State-changing commands take precedence over a phase expiry in the same cycle.
    if (cmd_valid_i) begin
      case (cmd)
        CMD_ON: if (!running) begin
          st_n  = S_RY;
          dir_n = '0;
          cnt_n = '0;
        end
        CMD_OFF: begin
          st_n  = S_OFF;
          cnt_n = '0;
        end
        CMD_UNREG: begin
          st_n   = S_UNREG;
          cnt_n  = '0;
          hcnt_n = '0;
          blk_n  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dem_n = dem | req_i;
    if (st_n == S_GREEN && st != S_GREEN) dem_n[dir_n] = 1'b0;
  end

  always_comb begin
    red_n    = '0;
    yellow_n = '0;
    green_n  = '0;
    case (st_n)
      S_UNREG: yellow_n = {N_DIR{blk_n}};
      S_RY: begin
        red_n           = '1;
        yellow_n[dir_n] = 1'b1;
      end
      S_GREEN: begin
        red_n          = '1;
        red_n[dir_n]   = 1'b0;
        green_n[dir_n] = 1'b1;
      end
      S_GBLINK: begin
        red_n          = '1;
        red_n[dir_n]   = 1'b0;
        green_n[dir_n] = blk_n;
      end
      S_YELLOW: begin
        red_n           = '1;
        red_n[dir_n]    = 1'b0;
        yellow_n[dir_n] = 1'b1;
      end
      S_ALLRED: red_n = '1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      st       <= S_OFF;
      dir      <= '0;
      cnt      <= '0;
      hcnt     <= '0;
      blk      <= 1'b0;
      dem      <= '0;
      red_o    <= '0;
      yellow_o <= '0;
      green_o  <= '0;
    end else begin
      st       <= st_n;
      dir      <= dir_n;
      cnt      <= cnt_n;
      hcnt     <= hcnt_n;
      blk      <= blk_n;
      dem      <= dem_n;
      red_o    <= red_n;
      yellow_o <= yellow_n;
      green_o  <= green_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int unsigned k = 0; k < unsigned'(N_DIR); k++) g_time[k] <= 16'(DEF_G_MS);
      y_time   <= 16'(DEF_Y_MS);
      clr_time <= 16'(DEF_CLR_MS);
      skip_en  <= 1'b0;
    end else if (cmd_valid_i) begin
      if (cmd == CMD_SKIP_EN) skip_en <= cmd_data_i[0];
      if (st == S_UNREG && cmd_data_i != '0) begin
        case (cmd)
          CMD_SET_GREEN:
            if (32'(cmd_dir_i) < unsigned'(N_DIR)) g_time[cmd_dir_i] <= cmd_data_i;
          CMD_SET_YELLOW: y_time   <= cmd_data_i;
          CMD_SET_CLEAR:  clr_time <= cmd_data_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Bench for traffic_lights_multi: elapsed-time reference model checked every
// cycle, plus literal lamp expectations at hand-computed cycle offsets.
module tb_traffic_lights_multi;

  localparam int TPM  = 2;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       srst;
  logic [2:0] cmd_type;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [15:0] cmd_data;
  logic [3:0] req;
  logic [3:0] red, yellow, green;

  traffic_lights_multi #(
    .N_DIR(4), .TICKS_PER_MS(2), .BLINK_Y_MS(5), .G_BLINK_T(4),
    .STATE_RY_MS(3), .DEF_G_MS(10), .DEF_Y_MS(4), .DEF_CLR_MS(2)
  ) dut (
    .clk_i(clk), .srst_i(srst), .cmd_type_i(cmd_type), .cmd_valid_i(cmd_valid),
    .cmd_dir_i(cmd_dir), .cmd_data_i(cmd_data), .req_i(req),
    .red_o(red), .yellow_o(yellow), .green_o(green)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 off, 1 blinking yellow, 2 running; phases 0..4 = RY, G, G-blink, Y, all-red.
  int m_mode, m_dir, m_ph, m_e, m_u, m_y, m_clr;
  int m_g [4];
  bit m_skip;
  bit [3:0] m_dem, dem_old;
  int old_mode;

  function automatic int ph_len(int ph, int d);
    case (ph)
      0:       return 3 * TPM;
      1:       return m_g[d] * TPM;
      2:       return 4 * 2 * HALF;
      3:       return m_y * TPM;
      default: return m_clr * TPM;
    endcase
  endfunction

  function automatic int pick(int d, bit [3:0] dm, bit sk);
    for (int i = 1; i <= 4; i++)
      if (sk && dm[(d + i) % 4]) return (d + i) % 4;
    return (d + 1) % 4;
  endfunction

  always @(posedge clk) begin
    if (srst) begin
      m_mode = 0; m_dir = 0; m_ph = 0; m_e = 0; m_u = 0;
      for (int k = 0; k < 4; k++) m_g[k] = 10;
      m_y = 4; m_clr = 2; m_skip = 1'b0; m_dem = '0;
    end else begin
      dem_old  = m_dem;
      old_mode = m_mode;
      m_dem    = m_dem | req;
      if (cmd_valid && cmd_type == 3'd6) m_skip = cmd_data[0];
      if (cmd_valid && old_mode == 1 && cmd_data != 0) begin
        if (cmd_type == 3'd3) m_g[cmd_dir] = cmd_data;
        if (cmd_type == 3'd4) m_y = cmd_data;
        if (cmd_type == 3'd5) m_clr = cmd_data;
      end
      if (old_mode == 2) begin
        m_e++;
        if (m_e == ph_len(m_ph, m_dir)) begin
          m_e = 0;
          if (m_ph == 4) begin
            m_dir = pick(m_dir, dem_old, m_skip);
            m_ph  = 0;
          end else m_ph++;
        end
      end
      if (old_mode == 1) m_u++;
      if (cmd_valid) begin
        if (cmd_type == 3'd0 && old_mode != 2) begin
          m_mode = 2; m_dir = 0; m_ph = 0; m_e = 0;
        end
        if (cmd_type == 3'd1) m_mode = 0;
        if (cmd_type == 3'd2) begin m_mode = 1; m_u = 0; end
      end
      if (m_mode == 2 && m_ph == 1 && m_e == 0) m_dem[m_dir] = 1'b0;
    end
  end

  function automatic logic [11:0] model_lamps();
    logic [3:0] r, y, g;
    r = '0; y = '0; g = '0;
    if (m_mode == 1) y = ((m_u / HALF) % 2 == 0) ? 4'hF : 4'h0;
    if (m_mode == 2) begin
      r = 4'hF;
      case (m_ph)
        0: y[m_dir] = 1'b1;
        1: begin r[m_dir] = 1'b0; g[m_dir] = 1'b1; end
        2: begin r[m_dir] = 1'b0; g[m_dir] = ((m_e / HALF) % 2 == 1); end
        3: begin r[m_dir] = 1'b0; y[m_dir] = 1'b1; end
        default: ;
      endcase
    end
    return {r, y, g};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] exp_l;
      exp_l = model_lamps();
      n_cmp++;
      if ({red, yellow, green} !== exp_l) begin
        n_bad++;
        $display("FAIL lamps t=%0t got r=%b y=%b g=%b want r=%b y=%b g=%b",
                 $time, red, yellow, green, exp_l[11:8], exp_l[7:4], exp_l[3:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] t, input logic [1:0] d, input logic [15:0] v);
    cmd_type = t; cmd_dir = d; cmd_data = v; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = '0; cmd_dir = '0; cmd_type = '0;
  endtask

  task automatic pulse(input logic [3:0] v);
    req = v;
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    srst = 1'b1; cmd_type = '0; cmd_valid = 1'b0; cmd_dir = '0; cmd_data = '0; req = '0;
    step(2);
    chk_en = 1'b1;
    chk("reset_red", red, 4'b0000);
    chk("reset_yellow", yellow, 4'b0000);
    chk("reset_green", green, 4'b0000);
    srst = 1'b0;

    // Default timing for approach 0, then hand-over to approach 1.
    send(3'd0, 2'd0, 16'd0);
    chk("ry_red", red, 4'b1111);
    chk("ry_yellow", yellow, 4'b0001);
    step(6);  chk("g0_green", green, 4'b0001); chk("g0_red", red, 4'b1110);
    step(19); chk("g0_last", green, 4'b0001);
    step(1);  chk("blink_off", green, 4'b0000); chk("blink_red", red, 4'b1110);
    step(5);  chk("blink_on", green, 4'b0001);
    step(35); chk("y0_yellow", yellow, 4'b0001); chk("y0_green", green, 4'b0000);
    step(8);  chk("clr_red", red, 4'b1111); chk("clr_yellow", yellow, 4'b0000);
    step(4);  chk("d1_ry", yellow, 4'b0010);

    // Blinking yellow.
    send(3'd2, 2'd0, 16'd0);
    chk("unreg_yellow", yellow, 4'b1111);
    chk("unreg_red", red, 4'b0000);
    chk("unreg_green", green, 4'b0000);
    step(4); chk("unreg_on_end", yellow, 4'b1111);
    step(1); chk("unreg_off", yellow, 4'b0000);
    step(5); chk("unreg_on2", yellow, 4'b1111);

    // Per-approach green; zero payload and running-mode SET are dropped.
    send(3'd3, 2'd2, 16'd3);
    send(3'd3, 2'd1, 16'd0);
    send(3'd0, 2'd0, 16'd0);
    step(162); chk("d2_green", green, 4'b0100);
    step(5);   chk("d2_green_last", green, 4'b0100);
    step(1);   chk("d2_blink_off", green, 4'b0000);
    send(3'd3, 2'd3, 16'd1);
    step(76);  chk("d3_green_last", green, 4'b1000);
    step(1);   chk("d3_blink_off", green, 4'b0000);

    // Demand-based skipping.
    send(3'd1, 2'd0, 16'd0);
    send(3'd6, 2'd0, 16'd1);
    send(3'd0, 2'd0, 16'd0);
    step(6);  chk("sk_g0", green, 4'b0001);
    pulse(4'b1000);
    step(70); chk("sk_clr_red", red, 4'b1111);
    step(1);  chk("sk_d3_ry", yellow, 4'b1000);
    step(6);  chk("sk_d3_green", green, 4'b1000);
    pulse(4'b1000);
    step(71); chk("sk_d3_again", yellow, 4'b1000);
    step(78); chk("sk_fallback_d0", yellow, 4'b0001);

    // OFF in approach 1's yellow; reserved command and ON-while-running ignored.
    send(3'd6, 2'd0, 16'd0);
    send(3'd1, 2'd0, 16'd0);
    send(3'd0, 2'd0, 16'd0);
    send(3'd7, 2'd0, 16'd5);
    send(3'd0, 2'd0, 16'd0);
    step(144); chk("d1_yellow", yellow, 4'b0010);
    send(3'd1, 2'd0, 16'd0);
    chk("off_all", red | yellow | green, 4'b0000);
    step(3); chk("off_hold", red | yellow | green, 4'b0000);
    send(3'd0, 2'd0, 16'd0);
    chk("restart_red", red, 4'b1111);
    chk("restart_yellow", yellow, 4'b0001);

    // Reset mid-green reverts configuration.
    send(3'd2, 2'd0, 16'd0);
    send(3'd4, 2'd0, 16'd1);
    send(3'd0, 2'd0, 16'd0);
    step(6);
    srst = 1'b1;
    step(1);
    chk("srst_all", red | yellow | green, 4'b0000);
    srst = 1'b0;
    send(3'd0, 2'd0, 16'd0);
    step(66); chk("rst_y_first", yellow, 4'b0001);
    step(7);  chk("rst_y_last", yellow, 4'b0001);
    step(1);  chk("rst_clr_red", red, 4'b1111); chk("rst_clr_yel", yellow, 4'b0000);
    step(5);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
